seq_chunk_adder: RTL
====================

Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle ripple-carry adder/subtractor.
- Adds two WIDTH-bit operands CHUNK bits per clock, starting from the LSB chunk, and holds the carry in a register between chunks.
- Valid/ready on input and output, so it can sit between a request source and a result consumer in a datapath.
- Replaces the fixed-width combinational adder. Adds width/chunk parameters, a subtract mode, a signed-overflow flag and handshaking.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 2, bits added per cycle; N = WIDTH/CHUNK cycles per operation; CHUNK == WIDTH is legal (N = 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub = 1.
- sub  in  1  0: a+b+cin; 1: a-b, computed as a + ~b + 1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB (not-borrow when sub = 1).
- overflow  out  1  two's-complement signed overflow.

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; sum=0; cout=0; overflow=0; chunk counter=0; carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: latch a, and b (or ~b when sub=1); load carry = sub ? 1 : cin; counter=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, chunk_rca adds chunk[counter] of the latched operands with the carry register.
  - The chunk result is written to sum bits [counter*CHUNK +: CHUNK]; the chunk carry-out goes to the carry register.
  - counter increments; after the cycle with counter == N-1, go to DONE.
  - In that last cycle, cout is captured from the chunk carry-out and overflow = (carry into MSB) XOR (carry out of MSB).
- DONE:
  - out_valid=1; sum, cout and overflow held stable.
  - On out_ready: go to IDLE.
  - in_ready rises on the following cycle; there is no same-cycle re-accept.
- Latency: out_valid rises exactly N cycles after the accepting clock edge. Throughput is one result per N+2 cycles at best.
- Operands are latched at accept; a and b may change during RUN without affecting the result.
- in_valid while busy is ignored (not queued).
- out_ready while out_valid=0 has no effect.
- sum is valid only while out_valid=1. Partial values are visible during RUN but are not architecturally defined.
- Reset mid-operation: abort immediately, return to reset values; no result is produced.
- Wrap-around: sum is modulo 2^WIDTH; the carry is reported only via cout.

Optional Feature:
- Macro: SEQ_CHUNK_ADDER_SAT_EN.
- Defined: on signed overflow, the captured sum saturates. If the latched a MSB = 0, sum = 0 followed by WIDTH-1 ones (max positive); otherwise sum = 1 followed by WIDTH-1 zeros (min negative). overflow and cout are still reported unchanged.
- Undefined: sum always wraps; no saturation logic is present.

Decomposition:
- Package seq_chunk_adder_pkg:
  - state enum typedef (IDLE, RUN, DONE).
  - Parameter-check function asserting WIDTH % CHUNK == 0 and CHUNK >= 1.
- Sub-module chunk_rca (combinational, parameter CHUNK):
  - CHUNK-bit ripple of full adders.
  - Outputs: sum chunk, carry-out, and carry into its MSB (needed for overflow).
  - Instantiated once; reused across cycles.

Test Plan (WIDTH=8, CHUNK=2 unless noted):
- Add with signed overflow: a=0x5A, b=0x3C, cin=0, sub=0.
  - Default build: sum=0x96, cout=0, overflow=1; out_valid exactly 4 cycles after accept.
  - With SEQ_CHUNK_ADDER_SAT_EN: sum=0x7F.
- Unsigned wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Same operands with cin=1 -> sum=0x01, cout=1.
- Subtract: a=0x10, b=0x20, sub=1, cin=1 (must be ignored) -> sum=0xF0, cout=0, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out_valid, sum and cout stay stable; in_ready stays 0; in_valid pulses are ignored.
  - out_ready=1 -> IDLE, and in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst_n=0 two cycles after accept.
  - All outputs return to reset values immediately; in_ready=1 after release; no out_valid.
- Config sweep: WIDTH=8, CHUNK=8 (N=1) and WIDTH=12, CHUNK=3 (N=4).
  - 1000 random a/b/cin/sub per config, compared against a reference model.
  - Latency equals N in each case.

Source files
------------

// File: rtl/seq_chunk_adder_pkg.sv
// +---------------------------------------------------------------------------+
// | seq_chunk_adder_pkg : FSM state type and parameter sanity check shared by  |
// |                       the seq_chunk_adder block.                           |
// | Revision 1.0                                                               |
// +---------------------------------------------------------------------------+
`default_nettype none

package seq_chunk_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic bit check_params(input int width, input int chunk);
      return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_chunk_adder_rca.sv
// +---------------------------------------------------------------------------+
// | chunk_rca : combinational CHUNK-bit ripple of full adders; also exposes    |
// |             the carry into its MSB so the caller can derive overflow.      |
// | Revision 1.0                                                               |
// +---------------------------------------------------------------------------+
`default_nettype none

module chunk_rca #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK:0] carry;

   assign carry[0] = cin;

   generate
      for (genvar i = 0; i < CHUNK; i++) begin : g_fa
         assign sum[i]     = a[i] ^ b[i] ^ carry[i];
         assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign cout  = carry[CHUNK];
   assign c_msb = carry[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/seq_chunk_adder.sv
// +---------------------------------------------------------------------------+
// | seq_chunk_adder : multi-cycle adder/subtractor, CHUNK bits per clock, with |
// |                   valid/ready handshakes. Option: SEQ_CHUNK_ADDER_SAT_EN.  |
// | Revision 1.0                                                               |
// +---------------------------------------------------------------------------+
`default_nettype none

module seq_chunk_adder
   import seq_chunk_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int            N    = WIDTH / CHUNK;
   localparam int            CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (!check_params(WIDTH, CHUNK)) begin : g_param_err
         $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [CHUNK-1:0] c_sum;
   logic             c_out;
   logic             c_msb;

   chunk_rca #(.CHUNK(CHUNK)) u_rca (
      .a     (op_a[int'(cnt)*CHUNK +: CHUNK]),
      .b     (op_b[int'(cnt)*CHUNK +: CHUNK]),
      .cin   (carry),
      .sum   (c_sum),
      .cout  (c_out),
      .c_msb (c_msb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (cnt == LAST) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Subtraction is folded in at accept time: b is inverted and the +1 rides in on the carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a     <= '0;
         op_b     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_a  <= a;
                  op_b  <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  cnt   <= '0;
               end
            end
            ST_RUN: begin
               sum[int'(cnt)*CHUNK +: CHUNK] <= c_sum;
               carry <= c_out;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  cnt      <= '0;
                  cout     <= c_out;
                  overflow <= c_msb ^ c_out;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
                  if (c_msb ^ c_out)
                     sum <= op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
